product_accumulator: RTL
========================

# product_accumulator

Sequential multiply-accumulate back end for the convolution datapath. It consumes the 8-bit product stream from the 4x4 array multiplier stage and sums a fixed-length group of LEN products, for example one 3x3 kernel window. It presents each group sum downstream on a valid/ready handshake, with unsigned saturation and a sticky overflow flag.

## Interface
- PROD_W, 8: product width; the upstream multiplier delivers unsigned values up to 225.
- LEN, 9: products per group; legal range is 1 or more.
- ACC_W, 16: accumulator and output width; legal range is ACC_W ≥ PROD_W.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous abort: discard the partial group and any held result.
- in_valid  in  1  in_prod is valid this cycle.
- in_ready  out  1  block can accept a product this cycle.
- in_prod  in  PROD_W  unsigned product.
- out_valid  out  1  out_sum and out_ovf are valid.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  ACC_W  group sum, saturated.
- out_ovf  out  1  a saturation occurred within this group.

## Operation
- States:
  - ACC: accumulating; in_ready=1, out_valid=0.
  - HOLD: result presented; in_ready=0, out_valid=1.
- Internal registers:
  - acc: ACC_W bits.
  - cnt: $clog2(LEN) bits, minimum 1.
  - ovf: sticky overflow flag.
- Accept rule: a product is accepted when in_valid && in_ready.
- Accept in ACC when cnt < LEN-1:
  - acc ← sat(acc + in_prod).
  - cnt ← cnt+1.
  - ovf ← ovf | carry.
- Accept in ACC when cnt == LEN-1:
  - out_sum ← sat(acc + in_prod).
  - out_ovf ← ovf | carry.
  - acc, cnt, ovf ← 0.
  - Next state is HOLD.
- Saturation: the add is computed ACC_W+1 bits wide. If bit ACC_W is set, the result is 2^ACC_W−1 and carry=1. Once acc is saturated, further adds keep it saturated.
- HOLD: out_sum and out_ovf are stable, and in_prod/in_valid are ignored. On out_valid && out_ready the block returns to ACC.
- LEN=1: every accepted product goes straight to HOLD.
- clear=1 in any state: next cycle is ACC with acc, cnt, ovf = 0 and out_valid=0. clear has priority over a simultaneous accept or output handshake; the beat is dropped and counts toward nothing.
- out_sum and out_ovf change only on entry to HOLD or on reset. Their value outside HOLD is don't-care for consumers.

## Timing
- Reset, on rst_n low, asynchronously:
  - state=ACC.
  - acc=0, cnt=0, ovf=0.
  - out_sum=0, out_ovf=0, out_valid=0.
  - in_ready=1 (combinational from state).
- Reset mid-group or mid-HOLD drops everything with no output.
- Latency: out_valid rises on the edge that accepts the LEN-th product, so it is visible in the cycle after that accept.
- Throughput:
  - With out_ready held high, one group takes LEN+1 cycles: LEN accepts plus one HOLD cycle.
  - in_ready is low exactly during HOLD cycles.
- Handshakes follow AXI-stream rules:
  - in_valid may not depend on in_ready.
  - out_valid, once high, stays high with stable data until out_ready or clear.
- in_valid gaps in ACC are allowed; cnt and acc hold.
- in_ready and out_valid are pure functions of state; there are no combinational paths from in_valid or out_ready.

## Test plan
- Reset: hold rst_n low 3 cycles, then release -> out_valid=0, out_sum=0, out_ovf=0, in_ready=1. Reassert rst_n asynchronously mid-cycle while in HOLD -> out_valid drops before the next edge.
- Basic group (LEN=9, ACC_W=16): stream 1..9 back-to-back with out_ready=1 -> out_sum=45, out_ovf=0, out_valid high one cycle after the 9th accept. A second group of nine 225s follows immediately -> out_sum=2025.
- Back-pressure and gaps: products 10,0,0,20,…,0 with in_valid gaps, then out_ready low 5 cycles -> out_sum=30 stable and in_ready=0 through all 5 cycles; products driven meanwhile are ignored. Releasing out_ready returns in_ready=1 on the next cycle.
- Saturation (ACC_W=10): nine products of 255 -> out_sum=1023, out_ovf=1. The next group of nine 1s -> out_sum=9, out_ovf=0, showing ovf is cleared per group.
- Clear: clear after 4 accepted products, then nine products of 2 -> out_sum=18. Clear during HOLD -> out_valid=0 on the next cycle and no result is delivered. Clear coincident with an accept -> that product is not counted.
- LEN=1: products 7, 225, 0 with out_ready=1 -> three results 7, 225, 0, each followed by a one-cycle in_ready=0.

Source files
------------

// File: rtl/product_accumulator.sv
// Sums groups of LEN unsigned products with saturation and a sticky overflow flag.
// Each group result is held on a valid/ready output until it is taken.
//
// state   | meaning
// ST_ACC  | accumulating products, in_ready=1, out_valid=0
// ST_HOLD | group result presented, in_ready=0, out_valid=1
module product_accumulator #(
  parameter int PROD_W = 8,
  parameter int LEN    = 9,
  parameter int ACC_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf
);

  localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W-1:0] sum_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic             ovf_d;
  logic             ovf_out_q;
  logic [ACC_W:0]   add_full;
  logic             carry;
  logic             accept;
  logic             last_beat;

  // One extra bit catches the wrap; a saturated acc stays pinned at all-ones.
  always_comb begin
    add_full = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_prod};
    carry    = add_full[ACC_W];
    acc_d    = carry ? '1 : add_full[ACC_W-1:0];
    ovf_d    = ovf_q | carry;
  end

  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = (state_q == ST_HOLD);
  assign accept    = in_valid && in_ready;
  assign last_beat = (cnt_q == CNT_LAST);
  assign out_sum   = sum_q;
  assign out_ovf   = ovf_out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_ACC;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      sum_q     <= '0;
      ovf_out_q <= 1'b0;
    end else if (clear) begin
      // The held result registers keep their value; they only matter in ST_HOLD.
      state_q <= ST_ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (accept) begin
            if (last_beat) begin
              sum_q     <= acc_d;
              ovf_out_q <= ovf_d;
              acc_q     <= '0;
              cnt_q     <= '0;
              ovf_q     <= 1'b0;
              state_q   <= ST_HOLD;
            end else begin
              acc_q <= acc_d;
              cnt_q <= cnt_q + CNT_W'(1);
              ovf_q <= ovf_d;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) state_q <= ST_ACC;
        end
        default: state_q <= ST_ACC;
      endcase
    end
  end

endmodule
